// File: rtl/frame_clear_engine.sv
// Rectangular clear/fill engine: sweeps an inclusive, clamped rectangle in raster order over a valid/ready write port.
// Optional macro FRAME_CLEAR_ABORT_EN adds an abort input that ends a running sweep early.
module frame_clear_engine #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int COORD_W = 11,
    parameter int DATA_W  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [DATA_W-1:0]  fill_value,
    input  logic               wr_ready,
`ifdef FRAME_CLEAR_ABORT_EN
    input  logic               abort,
`endif
    output logic               wr_en,
    output logic [COORD_W-1:0] x_coord,
    output logic [COORD_W-1:0] y_coord,
    output logic [DATA_W-1:0]  wr_data,
    output logic               busy,
    output logic               done
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [COORD_W-1:0] x1_clamp, y1_clamp;
    logic [COORD_W-1:0] x_lo, x_hi, y_hi;
    logic               empty;
    logic               row_end;
    logic               sweep_end;

    always_comb begin
        x1_clamp = (x1 > X_MAX) ? X_MAX : x1;
        y1_clamp = (y1 > Y_MAX) ? Y_MAX : y1;
        empty    = (x1_clamp < x0) || (y1_clamp < y0) || (x0 > X_MAX) || (y0 > Y_MAX);
    end

    // The accepted write at the bottom-right corner (or an abort) closes the sweep.
    always_comb begin
        row_end   = (x_coord == x_hi);
        sweep_end = wr_ready && row_end && (y_coord == y_hi);
`ifdef FRAME_CLEAR_ABORT_EN
        sweep_end = sweep_end || abort;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            x_coord <= '0;
            y_coord <= '0;
            wr_data <= '0;
            x_lo    <= '0;
            x_hi    <= '0;
            y_hi    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            wr_en   <= 1'b1;
                            busy    <= 1'b1;
                            x_lo    <= x0;
                            x_hi    <= x1_clamp;
                            y_hi    <= y1_clamp;
                            x_coord <= x0;
                            y_coord <= y0;
                            wr_data <= fill_value;
                        end
                    end
                end
                RUN: begin
                    if (sweep_end) begin
                        state <= DONE;
                        wr_en <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (wr_ready) begin
                        if (row_end) begin
                            x_coord <= x_lo;
                            y_coord <= y_coord + COORD_W'(1);
                        end else begin
                            x_coord <= x_coord + COORD_W'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
